led_matrix_scanner: RTL

- Display-side reader for the game's 24x16 LED matrix.
- Game logic writes rendered rows into a double-buffered frame store.
- Block time-multiplexes the front buffer onto the matrix: one row at a time, with blanking between rows, as registered row16/col24.
- Buffers swap only at frame boundaries, so the matrix never shows a torn frame.

---
 rtl/led_matrix_scanner_pkg.sv | 19 +
 rtl/led_matrix_scanner_if.sv | 30 +++
 rtl/led_matrix_scanner_frame_store_2bank.sv | 39 +++
 rtl/led_matrix_scanner.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/led_matrix_scanner_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_matrix_pkg : shared sizes, row/column types and scan states
// Rev 1.0
// ---------------------------------------------------------------------------
package led_matrix_pkg;
  localparam int ROWS = 16;
  localparam int COLS = 24;

  typedef logic [3:0]      row_idx_t;
  typedef logic [COLS-1:0] col_bits_t;
  typedef logic [ROWS-1:0] row_onehot_t;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;
endpackage
`default_nettype wire

// File: rtl/led_matrix_scanner_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_matrix_scanner_if : frame-write / swap handshake and matrix drive bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface led_matrix_scanner_if
  import led_matrix_pkg::*;
  ;
  logic        wr_en;
  row_idx_t    wr_row;
  col_bits_t   wr_data;
  logic        swap_req;
  logic [2:0]  bright;
  logic        swap_pending;
  logic        swap_ack;
  logic        frame_start;
  row_onehot_t row16;
  col_bits_t   col24;

  modport master (
    output wr_en, wr_row, wr_data, swap_req, bright,
    input  swap_pending, swap_ack, frame_start, row16, col24
  );

  modport slave (
    input  wr_en, wr_row, wr_data, swap_req, bright,
    output swap_pending, swap_ack, frame_start, row16, col24
  );
endinterface
`default_nettype wire

// File: rtl/led_matrix_scanner_frame_store_2bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_store_2bank : two-bank row store; writes go to the back bank,
//                     the front bank is read combinationally
// Rev 1.0
// ---------------------------------------------------------------------------
module frame_store_2bank
  import led_matrix_pkg::*;
(
  input  wire logic      clk50,
  input  wire logic      rst_n,
  input  wire logic      i_frontSel,
  input  wire logic      i_wrEn,
  input  wire row_idx_t  i_wrRow,
  input  wire col_bits_t i_wrData,
  input  wire row_idx_t  i_rdRow,
  output col_bits_t      o_rdData
);
  col_bits_t r_bank [2][ROWS];
  logic      w_wrValid;

  // Widened compare keeps the range guard meaningful if ROWS shrinks.
  assign w_wrValid = i_wrEn && ({1'b0, i_wrRow} < 5'(ROWS));

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          r_bank[b][r] <= '0;
        end
      end
    end else if (w_wrValid) begin
      r_bank[~i_frontSel][i_wrRow] <= i_wrData;
    end
  end

  assign o_rdData = r_bank[i_frontSel][i_rdRow];
endmodule
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_matrix_scanner : row-multiplexed scan of a double-buffered 24x16 matrix
// Optional per-row brightness PWM: LED_MATRIX_BRIGHTNESS_EN
// Rev 1.0
// ---------------------------------------------------------------------------
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROW_TICKS   = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  wire logic           clk50,
  input  wire logic           rst_n,
  led_matrix_scanner_if.slave bus
);
  localparam int TW = (ROW_TICKS > 2) ? $clog2(ROW_TICKS) : 1;
  localparam logic [TW-1:0] c_TICK_LAST  = TW'(ROW_TICKS - 1);
  localparam logic [TW-1:0] c_TICK_DRIVE = TW'(BLANK_TICKS);
  localparam row_idx_t      c_ROW_LAST   = row_idx_t'(ROWS - 1);

  logic [TW-1:0] r_tick, w_tickNext;
  row_idx_t      r_rowIdx, w_rowNext;
  scan_state_t   r_state, w_stateNext;
  logic          w_wrap, w_frameWrap;
  logic          r_frontSel, r_swapPending, r_swapAck, r_frameStart;
  row_onehot_t   r_row16, w_row16Next;
  col_bits_t     r_col24, w_col24Next, w_frontData;

  assign w_wrap      = (r_tick == c_TICK_LAST);
  assign w_frameWrap = w_wrap && (r_rowIdx == c_ROW_LAST);

  frame_store_2bank u_store (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .i_frontSel (r_frontSel),
    .i_wrEn     (bus.wr_en),
    .i_wrRow    (bus.wr_row),
    .i_wrData   (bus.wr_data),
    .i_rdRow    (r_rowIdx),
    .o_rdData   (w_frontData)
  );

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_tick   <= '0;
      r_rowIdx <= '0;
      r_state  <= BLANK;
    end else begin
      r_tick   <= w_tickNext;
      r_rowIdx <= w_rowNext;
      r_state  <= w_stateNext;
    end
  end

  always_comb begin
    w_tickNext  = r_tick + 1'b1;
    w_rowNext   = r_rowIdx;
    w_stateNext = r_state;
    if (w_wrap) begin
      w_tickNext  = '0;
      w_rowNext   = w_frameWrap ? '0 : r_rowIdx + 1'b1;
      w_stateNext = BLANK;
    end else if (w_tickNext == c_TICK_DRIVE) begin
      w_stateNext = DRIVE;
    end
  end

`ifdef LED_MATRIX_BRIGHTNESS_EN
  logic [2:0]    r_bright;
  logic [TW-1:0] w_driveTick;
  logic [31:0]   w_onTicks;
  logic          w_litOn;

  // Level is latched on DRIVE entry so a mid-row change cannot shorten it.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_bright <= '0;
    end else if (r_state == BLANK && w_stateNext == DRIVE) begin
      r_bright <= bus.bright;
    end
  end

  assign w_driveTick = r_tick - c_TICK_DRIVE;
  assign w_onTicks   = ((32'(r_bright) + 32'd1) * 32'(ROW_TICKS - BLANK_TICKS)) >> 3;
  assign w_litOn     = (32'(w_driveTick) < w_onTicks);
`else
  logic w_unusedBright;
  assign w_unusedBright = ^bus.bright;
`endif

  always_comb begin
    w_row16Next = '0;
    w_col24Next = '0;
    if (r_state == DRIVE) begin
      w_row16Next = row_onehot_t'(1) << r_rowIdx;
`ifdef LED_MATRIX_BRIGHTNESS_EN
      w_col24Next = w_litOn ? w_frontData : '0;
`else
      w_col24Next = w_frontData;
`endif
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_row16      <= '0;
      r_col24      <= '0;
      r_frameStart <= 1'b0;
    end else begin
      r_row16      <= w_row16Next;
      r_col24      <= w_col24Next;
      r_frameStart <= w_frameWrap;
    end
  end

  // A request arriving in the boundary cycle itself still swaps there.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_frontSel    <= 1'b0;
      r_swapPending <= 1'b0;
      r_swapAck     <= 1'b0;
    end else begin
      r_swapAck <= 1'b0;
      if (w_frameWrap && (r_swapPending || bus.swap_req)) begin
        r_frontSel    <= ~r_frontSel;
        r_swapPending <= 1'b0;
        r_swapAck     <= 1'b1;
      end else if (bus.swap_req) begin
        r_swapPending <= 1'b1;
      end
    end
  end

  assign bus.row16        = r_row16;
  assign bus.col24        = r_col24;
  assign bus.frame_start  = r_frameStart;
  assign bus.swap_ack     = r_swapAck;
  assign bus.swap_pending = r_swapPending;
endmodule
`default_nettype wire
